// File: rtl/mag_servo_scheduler.sv
// Per-frame FFT bin readout, bin-to-servo mapping, peak-hold with decay,
// and coherent publication of all servo values once per servo frame period.
module mag_servo_scheduler #(
    parameter int FCLK        = 50000000,
    parameter int FRAME_HZ    = 50,
    parameter int NBIN        = 8,
    parameter int NSERVO      = 5,
    parameter int W           = 13,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_valid,
    output logic [2:0]            bin_addr,
    input  logic [W-1:0]          bin_data,
    input  logic [3*NSERVO-1:0]   bin_map,
    output logic [W*NSERVO-1:0]   servo_mag,
    output logic                  servo_update,
    output logic                  busy,
    output logic [7:0]            overrun
);

    localparam int P      = FCLK / FRAME_HZ;
    localparam int TICK_W = (P > 1) ? $clog2(P) : 1;
    localparam int SEQ_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        APPLY
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SEQ_W-1:0]    seq_cnt;
    logic [SEQ_W-1:0]    seq_cnt_nxt;
    logic                frame_accept;
    logic                frame_drop;
    logic                cap_en;
    logic [2:0]          rd_bin;

    logic [3*NSERVO-1:0] map_r;
    logic [W-1:0]        new_mag  [NSERVO];
    logic [W-1:0]        held_mag [NSERVO];

    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic                pub_pending;

    // Peak hold: keep the larger of the fresh bin value and the decayed history.
    function automatic logic [W-1:0] decay_max(input logic [W-1:0] held,
                                               input logic [W-1:0] cand);
        logic [W-1:0] d;
        d = held - (held >> DECAY_SHIFT);
        return (cand > d) ? cand : d;
    endfunction

    always_comb begin
        state_nxt    = state;
        seq_cnt_nxt  = seq_cnt;
        busy         = 1'b0;
        bin_addr     = 3'd0;
        frame_accept = 1'b0;
        frame_drop   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_valid) begin
                    frame_accept = 1'b1;
                    state_nxt    = READ;
                    seq_cnt_nxt  = '0;
                end
            end
            READ: begin
                busy       = 1'b1;
                frame_drop = frame_valid;
                if (seq_cnt < SEQ_W'(NBIN)) begin
                    bin_addr = seq_cnt[2:0];
                end
                if (seq_cnt == SEQ_W'(NBIN)) begin
                    state_nxt   = APPLY;
                    seq_cnt_nxt = '0;
                end else begin
                    seq_cnt_nxt = seq_cnt + SEQ_W'(1);
                end
            end
            APPLY: begin
                busy       = 1'b1;
                frame_drop = frame_valid;
                if (seq_cnt == SEQ_W'(NSERVO - 1)) begin
                    state_nxt   = IDLE;
                    seq_cnt_nxt = '0;
                end else begin
                    seq_cnt_nxt = seq_cnt + SEQ_W'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                seq_cnt_nxt = '0;
            end
        endcase
    end

    // bin_data lags bin_addr by one cycle, so index k carries bin k-1.
    assign cap_en = (state == READ) && (seq_cnt != '0);
    assign rd_bin = 3'(seq_cnt - SEQ_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            seq_cnt <= '0;
            map_r   <= '0;
            overrun <= 8'd0;
            for (int i = 0; i < NSERVO; i++) begin
                new_mag[i]  <= '0;
                held_mag[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            seq_cnt <= seq_cnt_nxt;

            if (frame_accept) begin
                map_r <= bin_map;
                for (int i = 0; i < NSERVO; i++) begin
                    new_mag[i] <= '0;
                end
            end

            if (cap_en) begin
                for (int i = 0; i < NSERVO; i++) begin
                    if (map_r[3*i +: 3] == rd_bin) begin
                        new_mag[i] <= bin_data;
                    end
                end
            end

            if (state == APPLY) begin
                for (int i = 0; i < NSERVO; i++) begin
                    if (seq_cnt == SEQ_W'(i)) begin
                        held_mag[i] <= decay_max(held_mag[i], new_mag[i]);
                    end
                end
            end

            if (frame_drop && (overrun != 8'hFF)) begin
                overrun <= overrun + 8'd1;
            end
        end
    end

    assign tick = (tick_cnt == TICK_W'(P - 1));

    // A tick during APPLY is deferred so a publish never mixes old and new held values.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt     <= '0;
            pub_pending  <= 1'b0;
            servo_update <= 1'b0;
            servo_mag    <= '0;
        end else begin
            tick_cnt     <= tick ? '0 : tick_cnt + TICK_W'(1);
            servo_update <= 1'b0;
            if (state == APPLY) begin
                if (tick) begin
                    pub_pending <= 1'b1;
                end
            end else if (tick || pub_pending) begin
                pub_pending  <= 1'b0;
                servo_update <= 1'b1;
                for (int i = 0; i < NSERVO; i++) begin
                    servo_mag[W*i +: W] <= held_mag[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_mag_servo_scheduler.sv
// Directed bench for mag_servo_scheduler: registered bin source, publish
// scoreboard queue, and immediate-assertion checks.
module tb_mag_servo_scheduler;

    localparam int FCLK        = 1000;
    localparam int FRAME_HZ    = 10;
    localparam int P           = 100;
    localparam int NBIN        = 8;
    localparam int NSERVO      = 5;
    localparam int W           = 13;
    localparam int DECAY_SHIFT = 3;
    localparam int MW          = W * NSERVO;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            frame_valid = 1'b0;
    logic [2:0]      bin_addr;
    logic [W-1:0]    bin_data;
    logic [14:0]     bin_map = '0;
    logic [MW-1:0]   servo_mag;
    logic            servo_update;
    logic            busy;
    logic [7:0]      overrun;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [W-1:0]  bins_mem [NBIN];
    logic [W-1:0]  m_held   [NSERVO];
    logic [MW-1:0] exp_q [$];
    int            dec_exp [3];
    logic [14:0]   map_id;
    logic [14:0]   map_shared;
    int            u1, u2, u, e_cyc, n;

    mag_servo_scheduler #(
        .FCLK(FCLK), .FRAME_HZ(FRAME_HZ), .NBIN(NBIN), .NSERVO(NSERVO),
        .W(W), .DECAY_SHIFT(DECAY_SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid),
        .bin_addr(bin_addr), .bin_data(bin_data), .bin_map(bin_map),
        .servo_mag(servo_mag), .servo_update(servo_update),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bin_data <= bins_mem[bin_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_update(input string tag, output int ucyc);
        int k;
        k = 0;
        ucyc = -1;
        while (k < 3 * P) begin
            @(negedge clk);
            if (servo_update === 1'b1) begin
                ucyc = cyc;
                break;
            end
            k++;
        end
        checks++;
        assert (ucyc >= 0) else begin
            errors++;
            $error("FAIL %s: observed=no servo_update expected=update within %0d cycles", tag, 3 * P);
        end
    endtask

    task automatic check_publish(input string tag, output int ucyc);
        logic [MW-1:0] e;
        wait_update(tag, ucyc);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk(tag, servo_mag, e);
        @(negedge clk);
        chk({tag, "_width"}, servo_update, 1'b0);
    endtask

    function automatic logic [MW-1:0] pack_held();
        logic [MW-1:0] v;
        for (int i = 0; i < NSERVO; i++) v[W*i +: W] = m_held[i];
        return v;
    endfunction

    task automatic model_frame(input logic [14:0] map);
        logic [W-1:0] nv, d;
        for (int i = 0; i < NSERVO; i++) begin
            nv = bins_mem[map[3*i +: 3]];
            d  = m_held[i] - (m_held[i] >> DECAY_SHIFT);
            m_held[i] = (nv > d) ? nv : d;
        end
    endtask

    task automatic run_frame(input logic [14:0] map, input string tag);
        logic [2:0] ka;
        @(posedge clk); #1;
        bin_map = map;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            ka = k[2:0];
            if (k == 0) chk({tag, "_busy"}, busy, 1'b1);
            if (k < 8) chk({tag, "_addr"}, bin_addr, ka);
        end
        @(negedge clk);
        chk({tag, "_idle"}, busy, 1'b0);
        model_frame(map);
    endtask

    initial begin
        for (int k = 0; k < NBIN; k++) bins_mem[k] = '0;
        for (int i = 0; i < NSERVO; i++) m_held[i] = '0;
        dec_exp[0] = 700; dec_exp[1] = 613; dec_exp[2] = 537;
        map_id     = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        map_shared = {3'd0, 3'd7, 3'd2, 3'd2, 3'd2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", bin_addr, 3'd0);
        chk("rst_mag", servo_mag, '0);
        chk("rst_upd", servo_update, 1'b0);
        chk("rst_ovr", overrun, 8'd0);
        reset = 1'b0;

        // Idle publishing at the tick period
        exp_q.push_back('0);
        check_publish("t1_pub0", u1);
        exp_q.push_back('0);
        check_publish("t1_pub1", u2);
        chk("t1_period", 32'(u2 - u1), 32'(P));
        chk("t1_ovr", overrun, 8'd0);

        // Identity map
        for (int k = 0; k < NBIN; k++) bins_mem[k] = W'(100 * (k + 1));
        run_frame(map_id, "t2");
        exp_q.push_back(pack_held());
        check_publish("t2_pub", u);
        chk("t2_lit", servo_mag, {13'd500, 13'd400, 13'd300, 13'd200, 13'd100});

        // Decay on servo 0
        bins_mem[0] = 13'd800;
        run_frame(map_id, "t3a");
        exp_q.push_back(pack_held());
        check_publish("t3_pub800", u);
        chk("t3_s0_800", servo_mag[12:0], 13'd800);
        bins_mem[0] = 13'd0;
        for (int f = 0; f < 3; f++) begin
            run_frame(map_id, "t3b");
            exp_q.push_back(pack_held());
            check_publish("t3_pub", u);
            chk("t3_s0_decay", servo_mag[12:0], 13'(dec_exp[f]));
        end

        // Shared bin
        bins_mem[2] = 13'd4000;
        bins_mem[7] = 13'd8191;
        run_frame(map_shared, "t4");
        exp_q.push_back(pack_held());
        check_publish("t4_pub", u);
        chk("t4_s0", servo_mag[12:0], 13'd4000);
        chk("t4_s1", servo_mag[25:13], 13'd4000);
        chk("t4_s2", servo_mag[38:26], 13'd4000);
        chk("t4_s3", servo_mag[51:39], 13'd8191);

        // Overrun: pulse on the last busy edge is dropped, next edge accepted
        @(posedge clk); #1;
        bin_map = map_id;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        repeat (13) @(posedge clk);
        #1 frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        @(negedge clk);
        chk("t5_ovr1", overrun, 8'd1);
        chk("t5_idle", busy, 1'b0);
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        @(negedge clk);
        chk("t5_accept", busy, 1'b1);
        chk("t5_ovr_still1", overrun, 8'd1);
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t5_done", busy, 1'b0);

        frame_valid = 1'b1;
        repeat (450) @(posedge clk);
        #1 frame_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t5_sat", overrun, 8'd255);

        // Reset clears everything
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_ovr", overrun, 8'd0);
        chk("t6_rst_mag", servo_mag, '0);
        for (int i = 0; i < NSERVO; i++) m_held[i] = '0;

        // Tick landing in APPLY index 2
        for (int k = 0; k < NBIN; k++) bins_mem[k] = W'(1000 * k + 7);
        exp_q.push_back('0);
        check_publish("t6_pre", u);
        repeat (P - 14) @(posedge clk);
        #1 bin_map = map_id;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        e_cyc = u + P + 3;
        model_frame(map_id);
        exp_q.push_back(pack_held());
        check_publish("t6_apply_pub", u2);
        chk("t6_apply_cycle", 32'(u2), 32'(e_cyc));

        // Reset mid-READ aborts the frame and clears held values
        @(posedge clk); #1;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_mid_busy", busy, 1'b0);
        chk("t6_mid_addr", bin_addr, 3'd0);
        repeat (10) @(negedge clk);
        chk("t6_mid_stay_idle", busy, 1'b0);
        for (int i = 0; i < NSERVO; i++) m_held[i] = '0;
        exp_q.push_back(pack_held());
        check_publish("t6_mid_pub", u);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mag_servo_scheduler.md
# mag_servo_scheduler

Sequences per-frame readout of the 8 FFT magnitude bins and maps selected bins onto the 5 servo channels. Applies peak-hold with exponential decay to each servo value. Publishes the 5 values coherently once per servo frame period. Sits between fft_interface (bin source) and the servo instances (consumers), replacing direct bin-to-servo wiring.

## Interface
Parameters:
- FCLK, 50000000, clock frequency in Hz
- FRAME_HZ, 50, servo publish rate; tick period P = FCLK/FRAME_HZ cycles
- NBIN, 8, number of FFT bins; address width 3
- NSERVO, 5, number of servo channels
- W, 13, magnitude width
- DECAY_SHIFT, 3, decay per FFT frame is held >> DECAY_SHIFT

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_valid  in  1  one-cycle pulse: new bin set available from FFT
- bin_addr  out  3  bin read address
- bin_data  in  W  bin magnitude; valid the cycle after bin_addr is presented (registered read)
- bin_map  in  3*NSERVO  bin index for servo i in bits [3i+2:3i]; sampled at each accepted frame_valid
- servo_mag  out  W*NSERVO  published value for servo i in bits [W*i+W-1:W*i]
- servo_update  out  1  one-cycle pulse when servo_mag changes
- busy  out  1  high in any state other than IDLE
- overrun  out  8  saturating count of dropped frame_valid pulses

## Operation
- FSM states: IDLE, READ, APPLY.
- IDLE: on frame_valid, latch bin_map into map_r, clear new[0..4], then go to READ. Otherwise stay.
- READ: lasts NBIN+1 = 9 cycles, indexed k = 0..8.
  - For k < 8: bin_addr = k.
  - For k >= 1: bin_data is bin k-1. For every servo i with map_r[i] == k-1, set new[i] = bin_data.
  - Several servos may map to the same bin; all capture it.
  - After k = 8, go to APPLY.
- APPLY: lasts NSERVO = 5 cycles, j = 0..4, one servo per cycle:
  - d = held[j] - (held[j] >> DECAY_SHIFT)
  - held[j] = max(new[j], d)
  - Unsigned W-bit arithmetic; no overflow is possible.
  - After j = 4, go to IDLE.
- frame_valid while busy: the pulse is dropped, overrun increments (saturating at 255), and the FSM is unaffected.
- Tick counter: counts 0..P-1 and wraps; tick = (count == P-1).
- Publish on tick:
  - If not in APPLY: servo_mag = held[0..4] and servo_update = 1 the following cycle.
  - If in APPLY: set publish_pending. Publish on the first cycle after APPLY completes, so output is never a mix of old and new held values.
  - A second tick while still pending is merged into the one publish.
- bin_addr = 0 when not in READ.
- Reset values: state IDLE; bin_addr 0; servo_mag 0; servo_update 0; busy 0; overrun 0; held, new, map_r all 0; tick counter 0; publish_pending 0.
- Reset mid-READ or mid-APPLY aborts the frame. No partial held update survives.

## Timing
- frame_valid sampled high at edge T: busy = 1 and bin_addr = 0 from T+1.
- bin_addr = 7 at T+8; last capture at T+9.
- APPLY covers T+10..T+14; busy returns to 0 at T+15.
- Per-frame occupancy: 14 cycles. The next frame_valid is accepted at T+15 or later; one at T+14 counts as overrun.
- Publish latency from tick: 1 cycle when IDLE/READ; at most 6 cycles when the tick lands in APPLY.
- servo_update is exactly 1 cycle wide. Between frames, consecutive publishes are at least P cycles apart.

## Test plan
1. Reset, then FCLK=1000, FRAME_HZ=10 (P=100), no frames -> servo_update at cycles 100, 200, …; servo_mag = 0; overrun = 0.
2. bin_map = identity {0,1,2,3,4}; frame with bins = 100·(k+1) -> after the next tick, servo_mag = {100,200,300,400,500}; bin_addr sweeps 0..7 over T+1..T+8; busy low at T+15.
3. Decay: DECAY_SHIFT=3, servo 0 held = 800, following frames with bin0 = 0 -> held goes 700, 613, 537 on successive frames.
4. Shared bin: bin_map = {2,2,2,7,0}, bin2 = 4000, bin7 = 8191 -> servos 0–2 = 4000, servo 3 = 8191.
5. frame_valid at T and T+14 -> second pulse dropped, overrun = 1; a pulse at T+15 is accepted. 300 back-to-back overruns -> overrun holds at 255.
6. Tick landing in APPLY cycle 2 -> a single servo_update right after APPLY ends, showing all five post-apply values. Reset asserted mid-READ -> busy = 0, held = 0, next publish = 0.
